// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
// Each pipeline stage resolves one 4-bit lookahead group, so one 4-bit CLA
// sets the clock rate at any WIDTH. Valid/ready handshakes on both sides,
// and all stages share one advance enable.
// Optional build macro: CLA_PIPE_SAT_EN turns on signed saturation of s
// when the result overflows.

// One 4-bit lookahead group: sum bits plus group carry-out
module cla_pipe_grp (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       gg;
    logic       pg;

    // Generate/propagate terms, flat lookahead carries and group G/P
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pg   = &p;
        s    = p ^ c;
        cout = gg | (pg & cin);
    end
endmodule

module cla_pipe_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int L  = WIDTH / 4;
    // Operand words shrink by one group per stage and the sum word grows by
    // one group per stage. Both are packed as triangles so that no register
    // bit is dead: operand slice k is WIDTH-4k wide, sum slice k is 4k+4 wide.
    localparam int AT = L * WIDTH - 2 * L * (L - 1);
    localparam int ST = 2 * L * (L + 1);

    logic [AT-1:0]    a_tri, b_tri, a_nxt, b_nxt;
    logic [ST-1:0]    s_tri, s_nxt;
    logic [L:0]       c_q, c_nxt;
    logic [L:0]       vld_pipe;
    logic             ovf_q, ovf_nxt;
    logic             en;
    logic [WIDTH-1:0] s_raw;

    assign en       = out_ready | ~vld_pipe[L];
    assign in_ready = en;

    // Operand conditioning at acceptance: subtract is A + ~B + ~borrow
    assign a_nxt[WIDTH-1:0] = a;
    assign b_nxt[WIDTH-1:0] = sub ? ~b : b;
    assign c_nxt[0]         = sub ? ~ci : ci;

    genvar k;
    generate
        for (k = 0; k < L; k++) begin : g_stg
            localparam int AO = k * WIDTH - 2 * k * (k - 1);
            localparam int AW = WIDTH - 4 * k;
            localparam int SO = 2 * k * (k + 1);
            logic [3:0] grp_s;

            cla_pipe_grp u_grp (
                .a    (a_tri[AO +: 4]),
                .b    (b_tri[AO +: 4]),
                .cin  (c_q[k]),
                .s    (grp_s),
                .cout (c_nxt[k+1])
            );

            // Append the freshly resolved group above the lower sum groups
            if (k == 0) begin : g_s0
                assign s_nxt[3:0] = grp_s;
            end else begin : g_sk
                assign s_nxt[SO +: 4*k+4] = {grp_s, s_tri[SO-4*k +: 4*k]};
            end

            // Hand the still-unresolved upper groups to the next stage
            if (k < L - 1) begin : g_fwd
                assign a_nxt[AO+AW +: AW-4] = a_tri[AO+4 +: AW-4];
                assign b_nxt[AO+AW +: AW-4] = b_tri[AO+4 +: AW-4];
            end else begin : g_last
                // Carry into the MSB recovered as s ^ p; ovf = c[W] ^ c[W-1]
                assign ovf_nxt = c_nxt[L] ^ grp_s[3] ^ a_tri[AO+3] ^ b_tri[AO+3];
            end
        end
    endgenerate

    // Shift every stage together whenever the output slot can move
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            a_tri    <= '0;
            b_tri    <= '0;
            s_tri    <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[L-1:0], in_valid};
            a_tri    <= a_nxt;
            b_tri    <= b_nxt;
            s_tri    <= s_nxt;
            c_q      <= c_nxt;
            ovf_q    <= ovf_nxt;
        end
    end

    assign s_raw     = s_tri[ST-1 -: WIDTH];
    assign out_valid = vld_pipe[L];
    assign co        = c_q[L];
    assign ovf       = ovf_q;

`ifdef CLA_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    // A wrapped MSB of 1 means the true result was a too-large positive value
    assign s = ovf_q ? (s_raw[WIDTH-1] ? SAT_POS : SAT_NEG) : s_raw;
`else
    assign s = s_raw;
`endif
endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the combinational-circuits arithmetic library. Operands of WIDTH bits are split into 4-bit lookahead groups, and one group is resolved per pipeline stage, so the clock rate is set by a single 4-bit CLA regardless of width. Operands enter and results leave through valid/ready handshakes with full backpressure. Add/subtract is selectable per transaction, and a signed-overflow flag is reported with each result.

## Interface
Parameters:
- WIDTH, 16, operand/result width; multiple of 4, minimum 4; L = WIDTH/4 pipeline stages.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  pipeline can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = A+B+ci, 1 = A−B−ci.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference.
- co  output  1  carry-out of bit WIDTH−1; in sub mode 1 = no borrow.
- ovf  output  1  two's-complement overflow.

## Operation
- Operand conditioning at acceptance: b_eff = sub ? ~b : b; c0 = sub ? ~ci : ci.
- Per group k: g_i = a_i & b_eff_i; p_i = a_i ^ b_eff_i; internal carries by 4-bit lookahead from the group carry-in; s_i = p_i ^ c_i; group carry-out = G_k | (P_k & cin_k).
- Stage k (0..L−1) resolves group k from the carry registered by stage k−1 (stage 0 uses c0). Unresolved upper operand groups are carried forward unchanged. Resolved lower sum groups are delayed so that all groups align at the output.
- Each stage holds a valid bit. Bubbles propagate as invalid slots.
- Global advance enable: en = out_ready | ~out_valid. All stages shift only when en=1. in_ready = en. A transfer occurs when in_valid & in_ready.
- Final stage: co = carry out of group L−1; ovf = c[WIDTH] ^ c[WIDTH−1].
- Results leave in acceptance order. None is dropped or duplicated.
- Reset: all valid bits cleared; s = 0, co = 0, ovf = 0, out_valid = 0. in_ready = 1 from the first cycle after reset. Any in-flight transactions are discarded.

## Timing
- Latency: a transaction accepted at edge n has out_valid=1 after edge n+L, provided no stall occurred.
- Throughput: one transaction per cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0, every stage holds; s/co/ovf stay stable, and in_ready=0 in the same cycle (combinational from out_ready).
- Empty pipe with out_ready=0: en=1, so the pipe keeps filling until a valid result reaches the output.
- Simultaneous output transfer and input acceptance in the same cycle is legal and loses nothing.
- rst_n low at an edge overrides all handshakes.

## Configuration
- Macro CLA_PIPE_SAT_EN.
- When defined: on ovf=1, s is replaced with the signed saturation value. If the raw result MSB is 1 (positive overflow), s = 0x7F…F. Otherwise s = 0x80…0. ovf and co still report the raw condition.
- When undefined: s is always the raw wrapped result and no saturation logic is instantiated.

## Test plan
- WIDTH=16, add 0xFFFF+0x0001, ci=0, out_ready=1 → s=0x0000, co=1, ovf=0; out_valid exactly 4 cycles after acceptance.
- Sub 0x0005−0x0007, ci=0 → s=0xFFFE, co=0, ovf=0. Sub 0x0007−0x0005, ci=1 → s=0x0001, co=1.
- Add 0x7FFF+0x0001 → ovf=1; s=0x8000 without CLA_PIPE_SAT_EN, s=0x7FFF with it. Sub 0x8000−0x0001 → ovf=1; s=0x7FFF without the macro, 0x8000 with it.
- Backpressure: 6 back-to-back transactions, out_ready held low for 3 cycles mid-stream → in_ready low during the stall, output held stable, all 6 results correct and in order.
- Reset mid-flight: assert rst_n=0 for one edge with 3 transactions in the pipe → out_valid=0, s=0, no stale result ever appears; a new transaction afterwards completes with latency 4.
- WIDTH=4 (L=1) and WIDTH=32 (L=8): random add/sub of 1000 vectors checked against a reference model; latency equals L.
